// File: rtl/laser_pkg.sv
// Shared types and helpers for the laser two-circle coverage scheduler.
//   N_PTS     : points per frame (sweep length per candidate)
//   coord_t   : 4-bit grid coordinate
//   cnt_t     : 6-bit point count (maximum 40)
//   mask_t    : one bit per frame point
//   state_t   : scheduler FSM states
//   pos_t     : candidate/center position payload
//   circle_t  : selected center plus its full coverage mask
//   popcount  : number of set bits in a point mask
package laser_pkg;

  localparam int unsigned N_PTS   = 40;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned CNT_W   = 6;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [N_PTS-1:0]   mask_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  typedef struct packed {
    pos_t  pos;
    mask_t mask;
  } circle_t;

  function automatic cnt_t popcount(input mask_t m);
    cnt_t c;
    c = '0;
    for (int i = 0; i < int'(N_PTS); i++) begin
      c = c + cnt_t'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/laser_cand_gen.sv
// Candidate center raster counter: x inner 0..15, y outer 0..15.
//   CLK, RST : clock, asynchronous active-high reset
//   start    : restart the raster at (0,0)
//   step     : advance to the next candidate (wraps to (0,0) after (15,15))
//   x, y     : current candidate (registered)
//   last_c   : current candidate is (15,15)
module laser_cand_gen
  import laser_pkg::*;
(
  input  logic   CLK,
  input  logic   RST,
  input  logic   start,
  input  logic   step,
  output coord_t x,
  output coord_t y,
  output logic   last_c
);

  // Raster position; y advances when x rolls over.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      x <= x + coord_t'(1);
      if (x == '1) begin
        y <= y + coord_t'(1);
      end
    end
  end

  assign last_c = (x == '1) && (y == '1);

endmodule

// File: rtl/laser_pair_sched.sv
// Two-circle coverage search controller. Walks every 16x16 candidate center,
// sweeping the 40 point indices through the external hit engine one per cycle,
// alternating passes that optimise C1 and C2 until a pass gives no gain or the
// pass limit is reached.
//   CLK, RST          : clock, asynchronous active-high reset
//   START             : one-cycle request, accepted only in IDLE
//   BUSY              : search in progress
//   DONE              : one-cycle pulse, C1X/C1Y/C2X/C2Y valid
//   PT_IDX            : point index presented to the hit engine
//   CAND_X, CAND_Y    : candidate center presented to the hit engine
//   HIT               : combinational engine result for (CAND, PT_IDX)
//   C1X, C1Y, C2X, C2Y: selected centers
// Parameter MAX_PASS : hard limit on search passes (>= 2).
// Macro LASER_SCHED_EARLY_EXIT_EN : abort a candidate sweep once it can no
//   longer beat the best total; results are unchanged, cycle count shrinks.
module laser_pair_sched
  import laser_pkg::*;
#(
  parameter int unsigned MAX_PASS = 6
)
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic               BUSY,
  output logic               DONE,
  output logic [CNT_W-1:0]   PT_IDX,
  output logic [COORD_W-1:0] CAND_X,
  output logic [COORD_W-1:0] CAND_Y,
  input  logic               HIT,
  output logic [COORD_W-1:0] C1X,
  output logic [COORD_W-1:0] C1Y,
  output logic [COORD_W-1:0] C2X,
  output logic [COORD_W-1:0] C2Y
);

  localparam int unsigned PASS_W  = $clog2(MAX_PASS) + 1;
  localparam cnt_t        LAST_PT = cnt_t'(N_PTS - 1);

  state_t              state_q, state_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  cnt_t                pt_q, pt_d;
  cnt_t                k_q, k_d;
  mask_t               m_q, m_d;
  mask_t               f_q, f_d;
  cnt_t                fcnt_q, fcnt_d;
  cnt_t                best_q, best_d;
  mask_t               best_mask_q, best_mask_d;
  circle_t             c1_q, c1_d;
  circle_t             c2_q, c2_d;
  logic                improved_q, improved_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  pos_t                res1_q, res1_d;
  pos_t                res2_q, res2_d;

  logic                cand_start_c;
  logic                cand_step_c;
  logic                cand_last_c;
  coord_t              cand_x;
  coord_t              cand_y;
  pos_t                cand_pos_c;

  mask_t               pt_bit_c;
  logic                qual_c;
  cnt_t                k_new_c;
  mask_t               m_new_c;
  cnt_t                u_c;
  logic                cand_end_c;
  logic                abort_c;
  logic [PASS_W-1:0]   pass_nx_c;
  circle_t             fixed_c;

  laser_cand_gen u_cand (
    .CLK    (CLK),
    .RST    (RST),
    .start  (cand_start_c),
    .step   (cand_step_c),
    .x      (cand_x),
    .y      (cand_y),
    .last_c (cand_last_c)
  );

  assign cand_pos_c = '{x: cand_x, y: cand_y};

  // Per-cycle accumulation: M keeps every hit (the circle's own coverage),
  // K counts only hits outside the fixed circle, so F|M and popcount(F)+K agree.
  assign pt_bit_c   = mask_t'(1) << pt_q;
  assign qual_c     = HIT & ~f_q[pt_q];
  assign k_new_c    = k_q + cnt_t'(qual_c);
  assign m_new_c    = HIT ? (m_q | pt_bit_c) : m_q;
  assign u_c        = fcnt_q + k_new_c;
  assign cand_end_c = (pt_q == LAST_PT);

`ifdef LASER_SCHED_EARLY_EXIT_EN
  // Upper bound on this candidate's total; one extra bit since F and the
  // remaining points may overlap.
  logic [CNT_W:0] bound_c;
  assign bound_c = {1'b0, u_c} + {1'b0, LAST_PT - pt_q};
  assign abort_c = (bound_c <= {1'b0, best_q});
`else
  assign abort_c = 1'b0;
`endif

  // Next pass searches C2 when odd, so the fixed circle is C1 then.
  assign pass_nx_c = pass_q + PASS_W'(1);
  assign fixed_c   = pass_nx_c[0] ? c1_q : c2_q;

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      pass_q      <= '0;
      pt_q        <= '0;
      k_q         <= '0;
      m_q         <= '0;
      f_q         <= '0;
      fcnt_q      <= '0;
      best_q      <= '0;
      best_mask_q <= '0;
      c1_q        <= '0;
      c2_q        <= '0;
      improved_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res1_q      <= '0;
      res2_q      <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      pt_q        <= pt_d;
      k_q         <= k_d;
      m_q         <= m_d;
      f_q         <= f_d;
      fcnt_q      <= fcnt_d;
      best_q      <= best_d;
      best_mask_q <= best_mask_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      improved_q  <= improved_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res1_q      <= res1_d;
      res2_q      <= res2_d;
    end
  end

  // Next-state and register update logic.
  always_comb begin
    state_d      = state_q;
    pass_d       = pass_q;
    pt_d         = pt_q;
    k_d          = k_q;
    m_d          = m_q;
    f_d          = f_q;
    fcnt_d       = fcnt_q;
    best_d       = best_q;
    best_mask_d  = best_mask_q;
    c1_d         = c1_q;
    c2_d         = c2_q;
    improved_d   = improved_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    res1_d       = res1_q;
    res2_d       = res2_q;
    cand_start_c = 1'b0;
    cand_step_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d      = SCAN;
          pass_d       = '0;
          pt_d         = '0;
          k_d          = '0;
          m_d          = '0;
          f_d          = '0;
          fcnt_d       = '0;
          best_d       = '0;
          best_mask_d  = '0;
          c1_d         = '0;
          c2_d         = '0;
          improved_d   = 1'b0;
          busy_d       = 1'b1;
          cand_start_c = 1'b1;
        end
      end

      SCAN: begin
        if (cand_end_c || abort_c) begin
          // Strict '>' keeps the earlier candidate on ties.
          if (cand_end_c && (u_c > best_q)) begin
            best_d      = u_c;
            best_mask_d = f_q | m_new_c;
            improved_d  = 1'b1;
            if (pass_q[0]) begin
              c2_d = '{pos: cand_pos_c, mask: m_new_c};
            end else begin
              c1_d = '{pos: cand_pos_c, mask: m_new_c};
            end
          end
          pt_d        = '0;
          k_d         = '0;
          m_d         = '0;
          cand_step_c = 1'b1;
          if (cand_last_c) begin
            state_d = CHECK;
          end
        end else begin
          pt_d = pt_q + cnt_t'(1);
          k_d  = k_new_c;
          m_d  = m_new_c;
        end
      end

      CHECK: begin
        if ((pass_q != '0) &&
            (!improved_q || (pass_nx_c == PASS_W'(MAX_PASS)))) begin
          state_d = FINISH;
        end else begin
          state_d    = SCAN;
          pass_d     = pass_nx_c;
          f_d        = fixed_c.mask;
          fcnt_d     = popcount(fixed_c.mask);
          improved_d = 1'b0;
          if (pass_q == '0) begin
            c2_d   = c1_q;
            best_d = popcount(c1_q.mask);
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        res1_d  = c1_q.pos;
        res2_d  = c2_q.pos;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign PT_IDX = pt_q;
  assign CAND_X = cand_x;
  assign CAND_Y = cand_y;
  assign C1X    = res1_q.x;
  assign C1Y    = res1_q.y;
  assign C2X    = res2_q.x;
  assign C2Y    = res2_q.y;

endmodule

// File: tb/tb_laser_pair_sched.sv
// Self-checking bench for laser_pair_sched: two instances (MAX_PASS 6 and 2),
// each with its own frame and a circle hit engine (dx^2+dy^2 <= 16), checked
// against a whole-pass reference model built from per-candidate coverage masks.
module tb_laser_pair_sched;

  localparam int NP    = 40;
  localparam int LIMIT = 70000;
  localparam int PASS_CYC = 256 * 40 + 1;

  typedef logic [3:0] frm_t [NP];

  logic       CLK = 1'b0;
  logic       RST;
  logic       start_a, start_b;
  logic       busy_a, done_a, hit_a, busy_b, done_b, hit_b;
  logic [5:0] pt_a, pt_b;
  logic [3:0] cx_a, cy_a, c1x_a, c1y_a, c2x_a, c2y_a;
  logic [3:0] cx_b, cy_b, c1x_b, c1y_b, c2x_b, c2y_b;
  logic [31:0] out_a, out_b;

  frm_t fa_x, fa_y, fb_x, fb_y;

  int n_chk  = 0;
  int n_fail = 0;
  int prev_c1x, prev_c1y, prev_c2x, prev_c2y;

  always #5 CLK = ~CLK;

  laser_pair_sched #(.MAX_PASS(6)) dut (
    .CLK(CLK), .RST(RST), .START(start_a), .BUSY(busy_a), .DONE(done_a),
    .PT_IDX(pt_a), .CAND_X(cx_a), .CAND_Y(cy_a), .HIT(hit_a),
    .C1X(c1x_a), .C1Y(c1y_a), .C2X(c2x_a), .C2Y(c2y_a)
  );

  laser_pair_sched #(.MAX_PASS(2)) dut_lim (
    .CLK(CLK), .RST(RST), .START(start_b), .BUSY(busy_b), .DONE(done_b),
    .PT_IDX(pt_b), .CAND_X(cx_b), .CAND_Y(cy_b), .HIT(hit_b),
    .C1X(c1x_b), .C1Y(c1y_b), .C2X(c2x_b), .C2Y(c2y_b)
  );

  function automatic logic in_circle(input logic [3:0] cx, input logic [3:0] cy,
                                     input logic [3:0] px, input logic [3:0] py);
    int dx, dy;
    dx = int'(px) - int'(cx);
    dy = int'(py) - int'(cy);
    return (dx * dx + dy * dy) <= 16;
  endfunction

  always_comb hit_a = (int'(pt_a) < NP) &&
                      in_circle(cx_a, cy_a, fa_x[int'(pt_a) % NP], fa_y[int'(pt_a) % NP]);
  always_comb hit_b = (int'(pt_b) < NP) &&
                      in_circle(cx_b, cy_b, fb_x[int'(pt_b) % NP], fb_y[int'(pt_b) % NP]);

  assign out_a = {busy_a, done_a, pt_a, cx_a, cy_a, c1x_a, c1y_a, c2x_a, c2y_a};
  assign out_b = {busy_b, done_b, pt_b, cx_b, cy_b, c1x_b, c1y_b, c2x_b, c2y_b};

  // Reference: coverage set per candidate, union sizes by $countones, passes
  // alternating which circle moves; returns centers and number of passes run.
  function automatic void model(input frm_t px, input frm_t py, input int max_pass,
                                output int e1x, output int e1y, output int e2x,
                                output int e2y, output int npass);
    logic [NP-1:0] cov [256];
    logic [NP-1:0] fm;
    int c1, c2, best, u, p;
    bit imp;
    for (int c = 0; c < 256; c++) begin
      cov[c] = '0;
      for (int i = 0; i < NP; i++)
        cov[c][i] = in_circle(4'(c % 16), 4'(c / 16), px[i], py[i]);
    end
    c1 = 0;
    best = 0;
    for (int c = 0; c < 256; c++) begin
      u = $countones(cov[c]);
      if (u > best) begin best = u; c1 = c; end
    end
    c2 = c1;
    p = 1;
    best = $countones(cov[c1]);
    forever begin
      fm = (p % 2 == 1) ? cov[c1] : cov[c2];
      imp = 0;
      for (int c = 0; c < 256; c++) begin
        u = $countones(fm | cov[c]);
        if (u > best) begin
          best = u;
          imp = 1;
          if (p % 2 == 1) c2 = c; else c1 = c;
        end
      end
      if (!imp || p + 1 == max_pass) break;
      p++;
    end
    npass = p + 1;
    e1x = c1 % 16; e1y = c1 / 16; e2x = c2 % 16; e2y = c2 / 16;
  endfunction

  // Starts one or both instances, optionally re-pulses START on A at cycles
  // p1/p2 while busy, and measures cycles from acceptance to DONE.
  task automatic run_pair(input bit use_a, input bit use_b, input int p1, input int p2,
                          output int na, output int nb, output logic busy0,
                          output logic busy_end, output logic done_next);
    na = -1; nb = -1; busy0 = 1'bx; busy_end = 1'bx; done_next = 1'bx;
    @(negedge CLK); start_a = use_a; start_b = use_b;
    @(negedge CLK); start_a = 1'b0; start_b = 1'b0;
    for (int n = 0; n < LIMIT; n++) begin
      if (n == 0) busy0 = busy_a;
      if (use_a && na >= 0 && n == na + 1) done_next = done_a;
      if (use_a && na < 0 && done_a === 1'b1) begin na = n; busy_end = busy_a; end
      if (use_b && nb < 0 && done_b === 1'b1) nb = n;
      if ((!use_a || (na >= 0 && n > na)) && (!use_b || nb >= 0)) break;
      start_a = use_a && na < 0 && n > 0 && (n == p1 || n == p2);
      @(negedge CLK);
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; start_a = 1'b0; start_b = 1'b0;
    #12;
    n_chk++;
    if (out_a !== 32'h0) begin n_fail++; $display("FAIL reset_outputs_a: got %h want 0", out_a); end
    n_chk++;
    if (out_b !== 32'h0) begin n_fail++; $display("FAIL reset_outputs_b: got %h want 0", out_b); end
    @(negedge CLK); RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_chk++;
    if (out_a !== 32'h0) begin n_fail++; $display("FAIL idle_after_reset: got %h want 0", out_a); end
  endtask

  task automatic test_two_clusters_and_limit();
    int e1x, e1y, e2x, e2y, np, l1x, l1y, l2x, l2y, lnp, na, nb;
    logic busy0, busy_end, done_next;
    for (int i = 0; i < NP; i++) begin
      fa_x[i] = (i < 20) ? 4'd3 : 4'd12;
      fa_y[i] = (i < 20) ? 4'd3 : 4'd12;
      fb_x[i] = 4'($urandom_range(0, 15));
      fb_y[i] = 4'($urandom_range(0, 15));
    end
    model(fa_x, fa_y, 6, e1x, e1y, e2x, e2y, np);
    model(fb_x, fb_y, 2, l1x, l1y, l2x, l2y, lnp);
    run_pair(1'b1, 1'b1, -1, -1, na, nb, busy0, busy_end, done_next);
`ifdef LASER_SCHED_EARLY_EXIT_EN
    n_chk++;
    if (na < 0 || na >= 30724) begin n_fail++; $display("FAIL two_cluster_cycles: got %0d want < 30724", na); end
    n_chk++;
    if (nb < 0 || nb > lnp * PASS_CYC + 1) begin n_fail++; $display("FAIL limit_cycles: got %0d want <= %0d", nb, lnp * PASS_CYC + 1); end
`else
    n_chk++;
    if (na !== np * PASS_CYC + 1) begin n_fail++; $display("FAIL two_cluster_cycles: got %0d want %0d", na, np * PASS_CYC + 1); end
    n_chk++;
    if (na !== 30724) begin n_fail++; $display("FAIL two_cluster_cycles_abs: got %0d want 30724", na); end
    n_chk++;
    if (nb !== lnp * PASS_CYC + 1) begin n_fail++; $display("FAIL limit_cycles: got %0d want %0d", nb, lnp * PASS_CYC + 1); end
`endif
    n_chk++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy0); end
    n_chk++;
    if (busy_end !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b want 0", busy_end); end
    n_chk++;
    if (done_next !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", done_next); end
    n_chk++;
    if ({int'(c1x_a), int'(c1y_a), int'(c2x_a), int'(c2y_a)} !== {e1x, e1y, e2x, e2y}) begin
      n_fail++;
      $display("FAIL two_cluster_model: got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)",
               c1x_a, c1y_a, c2x_a, c2y_a, e1x, e1y, e2x, e2y);
    end
    n_chk++;
    if ({c1x_a, c1y_a, c2x_a, c2y_a} !== {4'd1, 4'd0, 4'd12, 4'd8}) begin
      n_fail++;
      $display("FAIL two_cluster_centers: got (%0d,%0d)(%0d,%0d) want (1,0)(12,8)",
               c1x_a, c1y_a, c2x_a, c2y_a);
    end
    n_chk++;
    if ({int'(c1x_b), int'(c1y_b), int'(c2x_b), int'(c2y_b)} !== {l1x, l1y, l2x, l2y}) begin
      n_fail++;
      $display("FAIL limit_model: got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)",
               c1x_b, c1y_b, c2x_b, c2y_b, l1x, l1y, l2x, l2y);
    end
    prev_c1x = e1x; prev_c1y = e1y; prev_c2x = e2x; prev_c2y = e2y;
  endtask

  task automatic test_mid_scan_reset();
    bit bad;
    repeat (10) @(negedge CLK);
    n_chk++;
    if ({int'(c1x_a), int'(c1y_a), int'(c2x_a), int'(c2y_a)} !== {prev_c1x, prev_c1y, prev_c2x, prev_c2y}) begin
      n_fail++;
      $display("FAIL result_hold: got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)",
               c1x_a, c1y_a, c2x_a, c2y_a, prev_c1x, prev_c1y, prev_c2x, prev_c2y);
    end
    for (int i = 0; i < NP; i++) begin fa_x[i] = 4'd5; fa_y[i] = 4'd5; end
    @(negedge CLK); start_a = 1'b1;
    @(negedge CLK); start_a = 1'b0;
    repeat (4999) @(negedge CLK);
    n_chk++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL busy_mid_scan: got %b want 1", busy_a); end
    RST = 1'b1;
    #1;
    n_chk++;
    if (out_a !== 32'h0) begin n_fail++; $display("FAIL mid_scan_reset: got %h want 0", out_a); end
    @(negedge CLK); RST = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (out_a !== 32'h0) bad = 1;
    end
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL idle_after_mid_reset: got %h want 0", out_a); end
  endtask

  task automatic test_single_cluster_busy_start();
    int e1x, e1y, e2x, e2y, np, na, nb, p1;
    logic busy0, busy_end, done_next;
    model(fa_x, fa_y, 6, e1x, e1y, e2x, e2y, np);
    p1 = int'($urandom_range(1, 9000));
    run_pair(1'b1, 1'b0, p1, 10240, na, nb, busy0, busy_end, done_next);
`ifdef LASER_SCHED_EARLY_EXIT_EN
    n_chk++;
    if (na < 0 || na >= 20483) begin n_fail++; $display("FAIL single_cycles: got %0d want < 20483", na); end
`else
    n_chk++;
    if (na !== np * PASS_CYC + 1) begin n_fail++; $display("FAIL single_cycles: got %0d want %0d", na, np * PASS_CYC + 1); end
    n_chk++;
    if (na !== 20483) begin n_fail++; $display("FAIL single_cycles_abs: got %0d want 20483", na); end
`endif
    n_chk++;
    if ({int'(c1x_a), int'(c1y_a), int'(c2x_a), int'(c2y_a)} !== {e1x, e1y, e2x, e2y}) begin
      n_fail++;
      $display("FAIL single_model: got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)",
               c1x_a, c1y_a, c2x_a, c2y_a, e1x, e1y, e2x, e2y);
    end
    n_chk++;
    if ({c1x_a, c1y_a, c2x_a, c2y_a} !== {4'd5, 4'd1, 4'd5, 4'd1}) begin
      n_fail++;
      $display("FAIL single_centers: got (%0d,%0d)(%0d,%0d) want (5,1)(5,1)",
               c1x_a, c1y_a, c2x_a, c2y_a);
    end
    n_chk++;
    if (done_next !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b want 0", done_next); end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      fa_x[i] = '0; fa_y[i] = '0; fb_x[i] = '0; fb_y[i] = '0;
    end
    test_reset();
    test_two_clusters_and_limit();
    test_mid_scan_reset();
    test_single_cluster_busy_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/laser_pair_sched.md
# laser_pair_sched

Controller that sequences the shared laser coverage-test datapath to choose two circle centers that together cover the most points of a loaded 40-point frame. It walks every candidate center on the 16x16 grid and sweeps the point indices through the external hit engine, one point per cycle. Passes alternate between optimising C1 and C2, with the other circle held fixed, until a pass yields no improvement. It sits between the frame loader, which pulses START, and the result output registers.

## Interface
- N_PTS, 40, points per frame; sweep length per candidate
- MAX_PASS, 6, hard limit on search passes, minimum 2
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- START  in  1  one-cycle request; frame buffer is already loaded
- BUSY  out  1  high from the cycle after START is accepted until FINISH
- DONE  out  1  one-cycle pulse; C1X/C1Y/C2X/C2Y are valid
- PT_IDX  out  6  point index presented to the hit engine
- CAND_X, CAND_Y  out  4 each  candidate center presented to the hit engine
- HIT  in  1  combinational engine result for (CAND, PT_IDX), valid in the same cycle
- C1X, C1Y, C2X, C2Y  out  4 each  selected centers

## Operation
- States: IDLE, SCAN, CHECK, FINISH.
- IDLE:
  - START=1 → SCAN with pass p=0, CAND=(0,0), PT_IDX=0.
  - START is ignored in every other state.
- SCAN sweep:
  - PT_IDX steps 0..39, one per cycle.
  - A hit counts only if the point is not set in the fixed-circle mask F.
  - The candidate mask M and count K (6 bit) accumulate.
- Candidate end (PT_IDX=39): the total is U = popcount(F) + K + final qualifying hit, computed that cycle.
  - If U > best, commit: the searched center, best=U, best mask = F|M.
  - Ties keep the earlier candidate.
- Candidate order: y outer 0..15, x inner 0..15. After (15,15), go to CHECK.
- Pass 0: search C1; F=0; best=0.
- Pass 1: fixed circle is C1; F = C1 mask; best = popcount(C1 mask); C2 is initialised to C1 before the search.
- Pass p≥2: odd p searches C2 with C1 fixed; even p searches C1 with C2 fixed.
  - F = mask of the fixed circle.
  - Baseline best = current best union.
- CHECK, one cycle:
  - After p=0, always go to pass 1.
  - After p≥1, go to FINISH if the pass made no strict improvement or p+1=MAX_PASS; otherwise go to SCAN with p+1.
- FINISH, one cycle: DONE=1, BUSY=0, then IDLE.
- C outputs hold their values until the next accepted START.
- Arithmetic:
  - Counts saturate-free in 6 bits (maximum 40).
  - Grid coordinates wrap is impossible because the scan stops at 15.

## Timing
- Reset values: every output is 0; state is IDLE; masks and best are 0.
- START accepted at edge t: SCAN begins at t+1.
- Each pass is 256×40 = 10240 cycles, followed by 1 CHECK cycle.
- DONE is asserted (P·10241)+1 cycles after acceptance, where P is the number of passes run.
- RST mid-operation: immediate return to IDLE with all reset values. No partial result is retained.
- HIT is sampled only while in SCAN and is ignored elsewhere.

## Configuration
- LASER_SCHED_EARLY_EXIT_EN defined:
  - A candidate sweep aborts as soon as popcount(F)+K+(39−PT_IDX) ≤ best, and the next candidate starts on the following cycle.
  - Selected centers are identical; the cycle count is reduced.
- Undefined: every candidate takes the full 40 cycles, and timing is exactly as stated above.

## Structure
- Package laser_pkg holds:
  - N_PTS
  - coord_t (4 bit)
  - cnt_t (6 bit)
  - the state enum {IDLE, SCAN, CHECK, FINISH}
  - the popcount function for 40-bit masks
- Sub-module laser_cand_gen: candidate x/y raster counter with start, step and last flag. The FSM, masks and best tracking stay in the top level.

## Test plan
Bench hit model: dx²+dy² ≤ 16.
- **Single cluster.** All 40 points at (5,5).
  - C1=(5,1), C2=(5,1), best=40.
  - DONE after 2 passes: 20483 cycles, macro off.
- **Two clusters.** 20 points at (3,3) and 20 at (12,12).
  - C1=(1,0), C2=(12,8).
  - Pass 2 gives no gain; DONE after 3 passes.
- **Mid-scan reset.** RST pulse at cycle 5000.
  - All outputs 0 and state IDLE.
  - A new START then produces the same result as a clean run.
- **START while busy.** Extra START pulses during SCAN and CHECK.
  - Ignored; cycle count and result are unchanged.
- **Pass limit.** MAX_PASS=2 with a frame that still improves in pass 2.
  - DONE after 2 passes, with the pass-1 result.
- **Early exit.** LASER_SCHED_EARLY_EXIT_EN defined, scenario 2 repeated.
  - Identical C1/C2.
  - DONE strictly earlier than 30724 cycles.
